regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, 32, register data width in bits.
REQ-002 SHALL have parameter NREGS, 32, register count (power of two, >=2); index width AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, 2, number of read ports.
REQ-004 SHALL have parameter NWR, 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wb_en  input  NWR  per-port write enable.
REQ-009 SHALL have port rd_index  input  NWR x AW  per-port write index.
REQ-010 SHALL have port wb_data  input  NWR x XLEN  per-port write data.
REQ-011 SHALL have port rs_index  input  NRD x AW  per-port read index.
REQ-012 SHALL have port rs_data_out  output  NRD x XLEN  per-port read data, combinational.
REQ-013 SHALL have port ecall_sig  input  1  environment-call request, one-cycle pulse.
REQ-014 SHALL have port svc_valid  output  1  service request to environment valid.
REQ-015 SHALL have port svc_ready  input  1  environment accepts service request.
REQ-016 SHALL have port svc_a0  output  XLEN  captured x10 value.
REQ-017 SHALL have port svc_a1  output  XLEN  captured x11 value.
REQ-018 SHALL have port stall  output  1  core must hold; high while service pending.
REQ-019 SHALL have port halt  output  1  sticky halt flag.

Function
REQ-020 SHALL hold register 0 at zero; writes to index 0 SHALL be discarded and reads return 0.
REQ-021 SHALL write wb_data[p] to rd_index[p] on the rising edge when wb_en[p]=1, halt=0 and stall=0.
REQ-022 SHALL resolve same-index multi-port writes by highest port number winning.
REQ-023 SHALL, when BYPASS=1, drive rs_data_out[q] from the winning enabled, non-zero-index write port matching rs_index[q] in the same cycle, else from storage.
REQ-024 SHALL implement service FSM states IDLE, REQ, HALTED.
REQ-025 SHALL transition IDLE->REQ on ecall_sig=1, capturing x10/x11 (post-bypass values) into svc_a0/svc_a1 on that edge.
REQ-026 SHALL assert svc_valid and stall throughout REQ, holding svc_a0/svc_a1 stable until handshake.
REQ-027 SHALL on svc_valid&&svc_ready go REQ->HALTED if svc_a0==0, else REQ->IDLE; stall deasserts the cycle after handshake.
REQ-028 SHALL ignore ecall_sig while in REQ or HALTED.
REQ-029 SHALL in HALTED assert halt, block all writes, keep reads functional, and leave HALTED only on reset.
REQ-030 SHALL block writes during REQ (stall=1) including writes presented in the ecall_sig cycle' successor cycles; writes in the ecall_sig cycle itself SHALL commit.

Reset
REQ-031 SHALL on reset clear all registers to 0, enter IDLE, and drive svc_valid=0, stall=0, halt=0, svc_a0=0, svc_a1=0, asynchronously.
REQ-032 SHALL abandon any pending REQ on reset mid-handshake without completing it.

Structure
REQ-033 SHALL place the FSM state enum and register ABI index constants (A0=10, A1=11) in shared package regfile_pkg.
REQ-034 SHALL use one sub-module, regfile_wr_arb, performing per-index write-port priority selection, reused by storage update and bypass.

Verification
REQ-035 SHALL check: write x5=0xDEADBEEF port0, read port1 same cycle (BYPASS=1) -> 0xDEADBEEF; BYPASS=0 -> old value 0.
REQ-036 SHALL check: port0 and port1 both write x7 (0x11, 0x22) -> x7=0x22 next cycle; write x0=0xFFFF -> reads 0.
REQ-037 SHALL check: x10=3, x11=9, ecall pulse, svc_ready delayed 4 cycles -> svc_valid/stall high 4 cycles, svc_a0=3, svc_a1=9 stable, then IDLE, halt=0.
REQ-038 SHALL check: x10=0, ecall, immediate ready -> halt=1 next cycle; subsequent write x3=1 ignored, x3 reads previous value.
REQ-039 SHALL check: reset asserted mid-REQ -> svc_valid, stall, halt, all registers 0 immediately, without clock edge.
REQ-040 SHALL check: second ecall_sig during REQ -> no recapture, single handshake only.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   svc_state_t : environment-service FSM states (IDLE, REQ, HALTED)
//   A0, A1      : ABI register indices whose values are handed to the
//                 environment on an ecall (x10 and x11)
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } svc_state_t;

  localparam int unsigned A0 = 10;
  localparam int unsigned A1 = 11;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port priority selector for a single register index.
// Reports whether any enabled write port targets i_index and, if so, which
// data wins. The highest-numbered matching port wins. Index 0 never matches
// because x0 is hard-wired to zero.
// Ports:
//   i_index    : register index being resolved
//   i_wb_en    : per-port write enable (already gated by the caller)
//   i_rd_index : per-port destination index
//   i_wb_data  : per-port write data
//   o_hit      : some enabled port writes i_index
//   o_data     : data from the winning port (0 when no hit)
module regfile_wr_arb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]            i_index,
  input  logic [NWR-1:0]           i_wb_en,
  input  logic [NWR-1:0][AW-1:0]   i_rd_index,
  input  logic [NWR-1:0][XLEN-1:0] i_wb_data,
  output logic                     o_hit,
  output logic [XLEN-1:0]          o_data
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is
    // inferred; blocking assignments let later (higher) ports overwrite
    // earlier ones, which is exactly the priority rule.
    o_hit  = 1'b0;
    o_data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wb_en[p] && (i_rd_index[p] == i_index) && (i_index != '0)) begin
        o_hit  = 1'b1;
        o_data = i_wb_data[p];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read forwarding and a
// small environment-service handshake (ecall -> request -> halt/resume).
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   wb_en/rd_index/wb_data : NWR write ports
//   rs_index/rs_data_out   : NRD combinational read ports
//   ecall_sig      : one-cycle environment-call pulse
//   svc_valid/svc_ready    : service request handshake
//   svc_a0/svc_a1  : x10/x11 captured when the ecall is accepted
//   stall          : core must hold while a request is pending
//   halt           : sticky, cleared only by reset
// NREGS must exceed A1 so that x10/x11 exist.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NWR-1:0]           wb_en,
  input  logic [NWR-1:0][AW-1:0]   rd_index,
  input  logic [NWR-1:0][XLEN-1:0] wb_data,
  input  logic [NRD-1:0][AW-1:0]   rs_index,
  output logic [NRD-1:0][XLEN-1:0] rs_data_out,
  input  logic                     ecall_sig,
  output logic                     svc_valid,
  input  logic                     svc_ready,
  output logic [XLEN-1:0]          svc_a0,
  output logic [XLEN-1:0]          svc_a1,
  output logic                     stall,
  output logic                     halt
);

  svc_state_t         r_state;
  svc_state_t         w_next;
  logic [XLEN-1:0]    r_regs [NREGS];
  logic [XLEN-1:0]    r_svc_a0;
  logic [XLEN-1:0]    r_svc_a1;

  logic               w_wr_allow;
  logic [NWR-1:0]     w_wb_en;
  logic [NREGS-1:0]   w_st_hit;
  logic [XLEN-1:0]    w_st_data [NREGS];
  logic [XLEN-1:0]    w_a0_fwd;
  logic [XLEN-1:0]    w_a1_fwd;

  // Writes commit only in IDLE: the ecall cycle itself is still IDLE, so its
  // writes land; REQ (stalled) and HALTED discard them. Forwarding uses the
  // same gated enables so a read never sees a write that will not commit.
  assign w_wr_allow = (r_state == IDLE);
  assign w_wb_en    = wb_en & {NWR{w_wr_allow}};

  // Storage update: one arbiter per register index.
  for (genvar i = 0; i < NREGS; i++) begin : g_st_arb
    regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
      .i_index    (AW'(i)),
      .i_wb_en    (w_wb_en),
      .i_rd_index (rd_index),
      .i_wb_data  (wb_data),
      .o_hit      (w_st_hit[i]),
      .o_data     (w_st_data[i])
    );
  end

  // NOTE: the architectural state must clear on reset, so the storage array
  // is reset here even though that rules out inferring a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      // The arbiter never hits index 0, so r_regs[0] stays zero.
      for (int i = 0; i < NREGS; i++) begin
        if (w_st_hit[i]) r_regs[i] <= w_st_data[i];
      end
    end
  end

  // Read ports.
  for (genvar q = 0; q < NRD; q++) begin : g_rd
    if (BYPASS != 0) begin : g_byp
      logic            w_hit;
      logic [XLEN-1:0] w_data;
      regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
        .i_index    (rs_index[q]),
        .i_wb_en    (w_wb_en),
        .i_rd_index (rd_index),
        .i_wb_data  (wb_data),
        .o_hit      (w_hit),
        .o_data     (w_data)
      );
      assign rs_data_out[q] = w_hit ? w_data : r_regs[rs_index[q]];
    end else begin : g_nobyp
      assign rs_data_out[q] = r_regs[rs_index[q]];
    end
  end

  // x10/x11 as they will be after this edge, so a write presented in the
  // ecall cycle is what the environment sees.
  assign w_a0_fwd = w_st_hit[A0] ? w_st_data[A0] : r_regs[A0];
  assign w_a1_fwd = w_st_hit[A1] ? w_st_data[A1] : r_regs[A1];

  // Service FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and outputs. Outputs decode the state only, so reset clears
  // them immediately without waiting for a clock.
  always_comb begin
    w_next    = r_state;
    svc_valid = 1'b0;
    stall     = 1'b0;
    halt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ecall_sig) w_next = REQ;
      end
      REQ: begin
        svc_valid = 1'b1;
        stall     = 1'b1;
        // ecall_sig is deliberately not looked at here.
        if (svc_ready) w_next = (r_svc_a0 == '0) ? HALTED : IDLE;
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Argument capture: only an ecall accepted from IDLE loads new values, so
  // they stay stable through REQ and ignore any repeated ecall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_svc_a0 <= '0;
      r_svc_a1 <= '0;
    end else if ((r_state == IDLE) && ecall_sig) begin
      r_svc_a0 <= w_a0_fwd;
      r_svc_a1 <= w_a1_fwd;
    end
  end

  assign svc_a0 = r_svc_a0;
  assign svc_a1 = r_svc_a1;

endmodule
